// File: rtl/rfphoenix_vec_reduce_pkg.sv
// Shared types for the vector lane-reduction unit: lane geometry, value types,
// reduction opcodes, FSM states and the per-opcode identity element.
package rfphoenix_vec_reduce_pkg;

    localparam int NLANES = 16;
    localparam int WID    = 32;

    typedef logic [WID-1:0]        Value;
    typedef logic [NLANES*WID-1:0] VecValue;

    typedef enum logic [2:0] {
        RED_SUM  = 3'd0,
        RED_AND  = 3'd1,
        RED_OR   = 3'd2,
        RED_XOR  = 3'd3,
        RED_MINS = 3'd4,
        RED_MAXS = 3'd5,
        RED_MINU = 3'd6,
        RED_MAXU = 3'd7
    } red_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } red_state_e;

    // Identity for a w-bit datapath (w <= 64), returned in the low w bits.
    function automatic logic [63:0] identity_w(red_op_e op, int unsigned w);
        logic [63:0] ones;
        logic [63:0] msb;
        ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        msb  = 64'd1 << (w - 1);
        case (op)
            RED_AND, RED_MINU: identity_w = ones;
            RED_MINS:          identity_w = ones >> 1;
            RED_MAXS:          identity_w = msb;
            default:           identity_w = '0;
        endcase
    endfunction

    function automatic Value identity(red_op_e op);
        logic [63:0] t;
        t = identity_w(op, WID);
        return t[WID-1:0];
    endfunction

endpackage

// File: rtl/rfphoenix_vec_reduce_if.sv
// Request/result handshake bundle between the execute stage and the reduction unit.
interface rfphoenix_vec_reduce_if #(
    parameter int NLANES = 16,
    parameter int WID    = 32
);
    localparam int CW = $clog2(NLANES) + 1;

    logic                  i_valid;
    logic                  i_ready;
    logic [2:0]            i_op;
    logic [NLANES-1:0]     i_mask;
    logic [NLANES*WID-1:0] i_a;
    logic                  o_valid;
    logic                  o_ready;
    logic [WID-1:0]        o_res;
    logic [CW-1:0]         o_cnt;

    modport master (
        output i_valid, i_op, i_mask, i_a, o_ready,
        input  i_ready, o_valid, o_res, o_cnt
    );

    modport slave (
        input  i_valid, i_op, i_mask, i_a, o_ready,
        output i_ready, o_valid, o_res, o_cnt
    );

endinterface

// File: rtl/rfphoenix_vec_reduce_red_op.sv
// Combinational fold step: combines the running accumulator with one lane value.
module rfphoenix_red_op
    import rfphoenix_vec_reduce_pkg::*;
#(
    parameter int WID = 32
) (
    input  red_op_e        op,
    input  logic [WID-1:0] acc,
    input  logic [WID-1:0] lane,
    output logic [WID-1:0] res
);

    logic signed [WID-1:0] acc_s;
    logic signed [WID-1:0] lane_s;

    assign acc_s  = acc;
    assign lane_s = lane;

    always_comb begin
        res = acc;
        case (op)
            RED_SUM:  res = acc + lane;
            RED_AND:  res = acc & lane;
            RED_OR:   res = acc | lane;
            RED_XOR:  res = acc ^ lane;
            RED_MINS: res = (lane_s < acc_s) ? lane : acc;
            RED_MAXS: res = (lane_s > acc_s) ? lane : acc;
            RED_MINU: res = (lane < acc) ? lane : acc;
            RED_MAXU: res = (lane > acc) ? lane : acc;
            default:  res = acc;
        endcase
    end

endmodule

// File: rtl/rfphoenix_vec_reduce.sv
// Sequential lane reduction: captures a vector, folds one active lane per clock
// for exactly NLANES cycles, then offers the scalar result on a valid/ready port.
module rfphoenix_vec_reduce
    import rfphoenix_vec_reduce_pkg::*;
#(
    parameter int NLANES = rfphoenix_vec_reduce_pkg::NLANES,
    parameter int WID    = rfphoenix_vec_reduce_pkg::WID
) (
    input  logic                   clk,
    input  logic                   rst,
    rfphoenix_vec_reduce_if.slave  bus
);

    localparam int LW = $clog2(NLANES);
    localparam int CW = LW + 1;

    red_state_e            state;
    red_state_e            state_nx;
    logic [LW-1:0]         lane_q;
    logic [CW-1:0]         cnt_q;
    logic [WID-1:0]        acc_q;
    red_op_e               op_q;
    logic [NLANES-1:0]     mask_q;
    logic [NLANES*WID-1:0] a_q;

    logic [WID-1:0]        lanes [NLANES];
    logic [WID-1:0]        lane_val;
    logic [WID-1:0]        fold_val;
    logic [63:0]           ident_w;
    red_op_e               op_in;

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign lanes[g] = a_q[g*WID +: WID];
    end

    assign op_in    = red_op_e'(bus.i_op);
    assign ident_w  = identity_w(op_in, WID);
    assign lane_val = lanes[lane_q];

    rfphoenix_red_op #(.WID(WID)) u_red_op (
        .op   (op_q),
        .acc  (acc_q),
        .lane (lane_val),
        .res  (fold_val)
    );

    assign bus.i_ready = (state == ST_IDLE);
    assign bus.o_valid = (state == ST_DONE);
    assign bus.o_res   = acc_q;
    assign bus.o_cnt   = cnt_q;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.i_valid) state_nx = ST_RUN;
            ST_RUN:  if (lane_q == LW'(NLANES - 1)) state_nx = ST_DONE;
            ST_DONE: if (bus.o_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            lane_q <= '0;
            cnt_q  <= '0;
            acc_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: if (bus.i_valid) begin
                    acc_q  <= ident_w[WID-1:0];
                    lane_q <= '0;
                    cnt_q  <= '0;
                end
                ST_RUN: begin
                    // Masked-off lanes still take a cycle so latency is mask-independent.
                    if (mask_q[lane_q]) begin
                        acc_q <= fold_val;
                        cnt_q <= cnt_q + 1'b1;
                    end
                    lane_q <= lane_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand capture: data-only registers, loaded on accept.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && bus.i_valid) begin
            op_q   <= op_in;
            mask_q <= bus.i_mask;
            a_q    <= bus.i_a;
        end
    end

endmodule

// File: tb/tb_rfphoenix_vec_reduce.sv
// Directed bench for rfphoenix_vec_reduce with hand-computed expected results.
module tb_rfphoenix_vec_reduce;
    import rfphoenix_vec_reduce_pkg::*;

    localparam int N = 16;
    localparam int W = 32;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rfphoenix_vec_reduce_if #(.NLANES(N), .WID(W)) bus ();

    rfphoenix_vec_reduce #(.NLANES(N), .WID(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] l [N]);
        logic [N*W-1:0] v;
        for (int g = 0; g < N; g++) v[g*W +: W] = l[g];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for i_ready, presents one request and returns after the accepting edge.
    task automatic start(input logic [2:0] op, input logic [N-1:0] mask, input logic [N*W-1:0] a);
        int n;
        n = 0;
        while (!bus.i_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("accept_timeout", 64'(n), 64'd0);
        bus.i_valid = 1'b1;
        bus.i_op    = op;
        bus.i_mask  = mask;
        bus.i_a     = a;
        tick();
        bus.i_valid = 1'b0;
        bus.i_a     = ~a;
        bus.i_mask  = ~mask;
        bus.i_op    = ~op;
    endtask

    // Edges are counted with the accepting edge as edge 1.
    task automatic wait_done(output logic [W-1:0] res, output logic [4:0] cnt, output int edges);
        edges = 1;
        while (!bus.o_valid && edges < 200) begin
            tick();
            edges++;
        end
        chk("done_valid", 64'(bus.o_valid), 64'd1);
        res = bus.o_res;
        cnt = bus.o_cnt;
    endtask

    task automatic ack();
        bus.o_ready = 1'b1;
        tick();
        bus.o_ready = 1'b0;
    endtask

    task automatic reduce(input logic [2:0] op, input logic [N-1:0] mask, input logic [N*W-1:0] a,
                          output logic [W-1:0] res, output logic [4:0] cnt, output int edges);
        start(op, mask, a);
        wait_done(res, cnt, edges);
        ack();
    endtask

    logic [W-1:0] l [N];
    logic [W-1:0] res;
    logic [4:0]   cnt;
    int           edges;
    logic [W-1:0] ident_tab [8];
    logic [W-1:0] mix_tab   [8];

    initial begin
        total = 0;
        bad   = 0;
        bus.i_valid = 1'b0;
        bus.i_op    = '0;
        bus.i_mask  = '0;
        bus.i_a     = '0;
        bus.o_ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_i_ready", 64'(bus.i_ready), 64'd1);
        chk("rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_o_res",   64'(bus.o_res),   64'd0);
        chk("rst_o_cnt",   64'(bus.o_cnt),   64'd0);

        // SUM of 1..16, all lanes
        for (int g = 0; g < N; g++) l[g] = W'(g + 1);
        reduce(3'd0, 16'hFFFF, pack(l), res, cnt, edges);
        chk("sum_res", 64'(res), 64'd136);
        chk("sum_cnt", 64'(cnt), 64'd16);
        chk("sum_lat", 64'(edges), 64'd17);
        chk("sum_idle_after", 64'(bus.i_ready), 64'd1);

        // MINS with lane 9 masked off
        for (int g = 0; g < N; g++) l[g] = 32'd5;
        l[3] = 32'hFFFF_FFF9;
        l[9] = 32'hFFFF_FFEC;
        reduce(3'd4, 16'hFDFF, pack(l), res, cnt, edges);
        chk("mins_res", 64'(res), 64'hFFFF_FFF9);
        chk("mins_cnt", 64'(cnt), 64'd15);

        // Signed vs unsigned max
        for (int g = 0; g < N; g++) l[g] = '0;
        l[0] = 32'h8000_0000;
        l[1] = 32'h7FFF_FFFF;
        reduce(3'd7, 16'h0003, pack(l), res, cnt, edges);
        chk("maxu_res", 64'(res), 64'h8000_0000);
        chk("maxu_cnt", 64'(cnt), 64'd2);
        reduce(3'd5, 16'h0003, pack(l), res, cnt, edges);
        chk("maxs_res", 64'(res), 64'h7FFF_FFFF);

        // Empty mask yields the identity of each op
        ident_tab = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0,
                      32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        for (int g = 0; g < N; g++) l[g] = 32'h1234_5678 + W'(g);
        for (int op = 0; op < 8; op++) begin
            reduce(3'(op), 16'h0000, pack(l), res, cnt, edges);
            chk($sformatf("empty_res_op%0d", op), 64'(res), 64'(ident_tab[op]));
            chk($sformatf("empty_cnt_op%0d", op), 64'(cnt), 64'd0);
        end

        // Three active lanes F0, 3C, 1E; inactive lanes all-ones
        mix_tab = '{32'h14A, 32'h10, 32'hFE, 32'hD2, 32'h1E, 32'hF0, 32'h1E, 32'hF0};
        for (int g = 0; g < N; g++) l[g] = 32'hFFFF_FFFF;
        l[0] = 32'hF0;
        l[1] = 32'h3C;
        l[2] = 32'h1E;
        for (int op = 0; op < 8; op++) begin
            reduce(3'(op), 16'h0007, pack(l), res, cnt, edges);
            chk($sformatf("mix_res_op%0d", op), 64'(res), 64'(mix_tab[op]));
            chk($sformatf("mix_cnt_op%0d", op), 64'(cnt), 64'd3);
        end

        // Backpressure: result held while o_ready low, new request waits
        for (int g = 0; g < N; g++) l[g] = W'(g + 1);
        start(3'd0, 16'hFFFF, pack(l));
        wait_done(res, cnt, edges);
        for (int g = 0; g < N; g++) l[g] = 32'd2;
        bus.i_a     = pack(l);
        bus.i_valid = 1'b1;
        bus.i_op    = 3'd0;
        bus.i_mask  = 16'hFFFF;
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid",   64'(bus.o_valid), 64'd1);
            chk("bp_res",     64'(bus.o_res),   64'd136);
            chk("bp_i_ready", 64'(bus.i_ready), 64'd0);
            tick();
        end
        ack();
        bus.i_valid = 1'b0;
        chk("bp_reaccept", 64'(bus.i_ready), 64'd1);
        reduce(3'd0, 16'hFFFF, pack(l), res, cnt, edges);
        chk("bp_new_res", 64'(res), 64'd32);
        chk("bp_new_cnt", 64'(cnt), 64'd16);

        // Reset in the middle of RUN, at lane 7
        for (int g = 0; g < N; g++) l[g] = 32'h1000;
        start(3'd0, 16'hFFFF, pack(l));
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_o_valid", 64'(bus.o_valid), 64'd0);
        chk("mid_rst_i_ready", 64'(bus.i_ready), 64'd1);
        chk("mid_rst_o_cnt",   64'(bus.o_cnt),   64'd0);
        chk("mid_rst_o_res",   64'(bus.o_res),   64'd0);
        begin
            int pulses;
            pulses = 0;
            for (int c = 0; c < N + 4; c++) begin
                if (bus.o_valid) pulses++;
                tick();
            end
            chk("mid_rst_no_valid", 64'(pulses), 64'd0);
        end
        for (int g = 0; g < N; g++) l[g] = W'(g + 1);
        reduce(3'd0, 16'hFFFF, pack(l), res, cnt, edges);
        chk("post_rst_res", 64'(res), 64'd136);
        chk("post_rst_cnt", 64'(cnt), 64'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
